// File: rtl/adjust_controller_if.sv
// Button/tick inputs and control/alarm outputs of the adjust controller.
// The master side drives the button pulses; the slave side is the controller.
interface adjust_controller_if;
  logic       btn_c;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       tick_1hz;
  logic       adj_mode;
  logic [1:0] field;
  logic       ch_inc;
  logic       ch_dec;
  logic       cm_inc;
  logic       cm_dec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_armed;

  modport master (
    output btn_c, btn_u, btn_d, btn_l, btn_r, tick_1hz,
    input  adj_mode, field, ch_inc, ch_dec, cm_inc, cm_dec,
    input  alarm_hour, alarm_min, alarm_armed
  );

  modport slave (
    input  btn_c, btn_u, btn_d, btn_l, btn_r, tick_1hz,
    output adj_mode, field, ch_inc, ch_dec, cm_inc, cm_dec,
    output alarm_hour, alarm_min, alarm_armed
  );
endinterface

// File: rtl/adjust_controller.sv
// Clock/alarm adjust-mode FSM: field selection, inc/dec pulses and alarm registers.
// Optional macro AUTO_EXIT_EN adds an inactivity timeout of TIMEOUT_S ticks of tick_1hz.
module adjust_controller #(
  parameter int TIMEOUT_S = 10
) (
  input logic               clk_in,
  input logic               rst,
  adjust_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_CLOCK  = 3'd0,
    S_ADJ_CH = 3'd1,
    S_ADJ_CM = 3'd2,
    S_ADJ_AH = 3'd3,
    S_ADJ_AM = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_adj_mode;
  logic [1:0] w_field;
  logic       w_timeout;

  // One-hot qualified buttons: only the highest-priority pulse survives.
  logic w_c, w_r, w_l, w_u, w_d;
  assign w_c = bus.btn_c;
  assign w_r = bus.btn_r & ~bus.btn_c;
  assign w_l = bus.btn_l & ~bus.btn_c & ~bus.btn_r;
  assign w_u = bus.btn_u & ~bus.btn_c & ~bus.btn_r & ~bus.btn_l;
  assign w_d = bus.btn_d & ~bus.btn_c & ~bus.btn_r & ~bus.btn_l & ~bus.btn_u;

  logic       r_ch_inc, r_ch_dec, r_cm_inc, r_cm_dec;
  logic [4:0] r_alarm_hour;
  logic [5:0] r_alarm_min;
  logic       r_alarm_armed;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= S_CLOCK;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLOCK:  if (w_c) w_state_next = S_ADJ_CH;
      S_ADJ_CH: begin
        if (w_c)      w_state_next = S_CLOCK;
        else if (w_r) w_state_next = S_ADJ_CM;
        else if (w_l) w_state_next = S_ADJ_AM;
      end
      S_ADJ_CM: begin
        if (w_c)      w_state_next = S_CLOCK;
        else if (w_r) w_state_next = S_ADJ_AH;
        else if (w_l) w_state_next = S_ADJ_CH;
      end
      S_ADJ_AH: begin
        if (w_c)      w_state_next = S_CLOCK;
        else if (w_r) w_state_next = S_ADJ_AM;
        else if (w_l) w_state_next = S_ADJ_CM;
      end
      S_ADJ_AM: begin
        if (w_c)      w_state_next = S_CLOCK;
        else if (w_r) w_state_next = S_ADJ_CH;
        else if (w_l) w_state_next = S_ADJ_AH;
      end
      default:        w_state_next = S_CLOCK;
    endcase
    if (w_timeout) w_state_next = S_CLOCK;
  end

  always_comb begin
    w_adj_mode = 1'b0;
    w_field    = 2'd0;
    case (r_state)
      S_ADJ_CH: begin w_adj_mode = 1'b1; w_field = 2'd0; end
      S_ADJ_CM: begin w_adj_mode = 1'b1; w_field = 2'd1; end
      S_ADJ_AH: begin w_adj_mode = 1'b1; w_field = 2'd2; end
      S_ADJ_AM: begin w_adj_mode = 1'b1; w_field = 2'd3; end
      default:  begin w_adj_mode = 1'b0; w_field = 2'd0; end
    endcase
  end

  // u/d are qualified only when no c/r/l is present, so a field move never
  // coincides with an inc/dec pulse or alarm change.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_ch_inc      <= 1'b0;
      r_ch_dec      <= 1'b0;
      r_cm_inc      <= 1'b0;
      r_cm_dec      <= 1'b0;
      r_alarm_hour  <= 5'd0;
      r_alarm_min   <= 6'd0;
      r_alarm_armed <= 1'b0;
    end else begin
      r_ch_inc <= (r_state == S_ADJ_CH) & w_u;
      r_ch_dec <= (r_state == S_ADJ_CH) & w_d;
      r_cm_inc <= (r_state == S_ADJ_CM) & w_u;
      r_cm_dec <= (r_state == S_ADJ_CM) & w_d;
      if (r_state == S_CLOCK && w_u) r_alarm_armed <= ~r_alarm_armed;
      if (r_state == S_ADJ_AH) begin
        if (w_u)      r_alarm_hour <= (r_alarm_hour == 5'd23) ? 5'd0 : r_alarm_hour + 5'd1;
        else if (w_d) r_alarm_hour <= (r_alarm_hour == 5'd0) ? 5'd23 : r_alarm_hour - 5'd1;
      end
      if (r_state == S_ADJ_AM) begin
        if (w_u)      r_alarm_min <= (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
        else if (w_d) r_alarm_min <= (r_alarm_min == 6'd0) ? 6'd59 : r_alarm_min - 6'd1;
      end
    end
  end

`ifdef AUTO_EXIT_EN
  localparam int CW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
  logic [CW-1:0] r_idle_cnt;
  logic          w_any_btn;
  assign w_any_btn = bus.btn_c | bus.btn_u | bus.btn_d | bus.btn_l | bus.btn_r;

  // Timeout fires on the tick that would bring the count to TIMEOUT_S; a button wins.
  assign w_timeout = (r_state != S_CLOCK) && bus.tick_1hz && !w_any_btn &&
                     (r_idle_cnt == CW'(TIMEOUT_S - 1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (w_any_btn || w_state_next == S_CLOCK) begin
      r_idle_cnt <= '0;
    end else if (r_state != S_CLOCK && bus.tick_1hz) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tick;
  assign w_unused_tick = bus.tick_1hz;
  assign w_timeout     = 1'b0;
`endif

  assign bus.adj_mode    = w_adj_mode;
  assign bus.field       = w_field;
  assign bus.ch_inc      = r_ch_inc;
  assign bus.ch_dec      = r_ch_dec;
  assign bus.cm_inc      = r_cm_inc;
  assign bus.cm_dec      = r_cm_dec;
  assign bus.alarm_hour  = r_alarm_hour;
  assign bus.alarm_min   = r_alarm_min;
  assign bus.alarm_armed = r_alarm_armed;

endmodule

// File: tb/tb_adjust_controller.sv
// Directed self-checking bench for adjust_controller (timeout test when AUTO_EXIT_EN is defined).
module tb_adjust_controller;
  logic clk_in = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BR = 5'b01000;
  localparam logic [4:0] BL = 5'b00100;
  localparam logic [4:0] BU = 5'b00010;
  localparam logic [4:0] BD = 5'b00001;
  localparam logic [4:0] NB = 5'b00000;

  adjust_controller_if bus ();

  adjust_controller #(.TIMEOUT_S(3)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // Apply one cycle of buttons/tick/reset, leaving outputs sampled 1 ns after the edge.
  task automatic drive(input logic [4:0] b, input logic t, input logic r);
    @(negedge clk_in);
    bus.btn_c = b[4]; bus.btn_r = b[3]; bus.btn_l = b[2];
    bus.btn_u = b[1]; bus.btn_d = b[0]; bus.tick_1hz = t; rst = r;
    @(posedge clk_in);
    #1;
    bus.btn_c = 0; bus.btn_r = 0; bus.btn_l = 0; bus.btn_u = 0; bus.btn_d = 0;
    bus.tick_1hz = 0; rst = 0;
    $display("txn btn=%b tick=%b rst=%b -> adj=%b field=%0d pulses=%b%b%b%b alarm=%0d:%0d armed=%b",
             b, t, r, bus.adj_mode, bus.field, bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec,
             bus.alarm_hour, bus.alarm_min, bus.alarm_armed);
  endtask

  task automatic test_reset();
    drive(NB, 1'b0, 1'b1);
    drive(NB, 1'b0, 1'b1);
    checks++; if (bus.adj_mode !== 1'b0) begin errors++; $display("FAIL reset_adj got=%b exp=0", bus.adj_mode); end
    checks++; if (bus.field !== 2'd0) begin errors++; $display("FAIL reset_field got=%0d exp=0", bus.field); end
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
    checks++; if (bus.alarm_hour !== 5'd0 || bus.alarm_min !== 6'd0 || bus.alarm_armed !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%0d:%0d/%b exp=0:0/0", bus.alarm_hour, bus.alarm_min, bus.alarm_armed); end
  endtask

  task automatic test_navigation();
    drive(BC, 1'b0, 1'b0);
    checks++; if (bus.adj_mode !== 1'b1 || bus.field !== 2'd0) begin errors++; $display("FAIL nav_enter got=%b/%0d exp=1/0", bus.adj_mode, bus.field); end
    drive(BR, 1'b0, 1'b0);
    checks++; if (bus.field !== 2'd1) begin errors++; $display("FAIL nav_r1 got=%0d exp=1", bus.field); end
    drive(BR, 1'b0, 1'b0);
    checks++; if (bus.field !== 2'd2) begin errors++; $display("FAIL nav_r2 got=%0d exp=2", bus.field); end
    drive(BC, 1'b0, 1'b0);
    checks++; if (bus.adj_mode !== 1'b0 || bus.field !== 2'd0) begin errors++; $display("FAIL nav_exit got=%b/%0d exp=0/0", bus.adj_mode, bus.field); end
    drive(BC, 1'b0, 1'b0);
    drive(BL, 1'b0, 1'b0);
    checks++; if (bus.field !== 2'd3) begin errors++; $display("FAIL nav_l_wrap got=%0d exp=3", bus.field); end
  endtask

  task automatic test_alarm_wrap();
    drive(BL, 1'b0, 1'b0);
    checks++; if (bus.field !== 2'd2) begin errors++; $display("FAIL wrap_to_ah got=%0d exp=2", bus.field); end
    drive(BD, 1'b0, 1'b0);
    checks++; if (bus.alarm_hour !== 5'd23) begin errors++; $display("FAIL hour_dec0 got=%0d exp=23", bus.alarm_hour); end
    drive(BU, 1'b0, 1'b0);
    checks++; if (bus.alarm_hour !== 5'd0) begin errors++; $display("FAIL hour_inc23 got=%0d exp=0", bus.alarm_hour); end
    drive(BD, 1'b0, 1'b0);
    checks++; if (bus.alarm_hour !== 5'd23) begin errors++; $display("FAIL hour_dec0b got=%0d exp=23", bus.alarm_hour); end
    drive(BR, 1'b0, 1'b0);
    drive(BD, 1'b0, 1'b0);
    checks++; if (bus.alarm_min !== 6'd59 || bus.alarm_hour !== 5'd23) begin errors++; $display("FAIL min_dec0 got=%0d:%0d exp=23:59", bus.alarm_hour, bus.alarm_min); end
    drive(BU, 1'b0, 1'b0);
    checks++; if (bus.alarm_min !== 6'd0 || bus.alarm_hour !== 5'd23) begin errors++; $display("FAIL min_inc59 got=%0d:%0d exp=23:0", bus.alarm_hour, bus.alarm_min); end
  endtask

  task automatic test_pulses();
    drive(BR, 1'b0, 1'b0);
    drive(BR, 1'b0, 1'b0);
    checks++; if (bus.field !== 2'd1) begin errors++; $display("FAIL pulse_cm_field got=%0d exp=1", bus.field); end
    drive(BU, 1'b0, 1'b0);
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0010) begin errors++; $display("FAIL cm_inc_pulse got=%b exp=0010", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
    drive(NB, 1'b0, 1'b0);
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0000) begin errors++; $display("FAIL cm_inc_width got=%b exp=0000", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
    drive(BD, 1'b0, 1'b0);
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0001) begin errors++; $display("FAIL cm_dec_pulse got=%b exp=0001", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
    drive(BL, 1'b0, 1'b0);
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0000 || bus.field !== 2'd0) begin errors++; $display("FAIL l_to_ch got=%b/%0d exp=0000/0", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}, bus.field); end
    drive(BU, 1'b0, 1'b0);
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b1000) begin errors++; $display("FAIL ch_inc_pulse got=%b exp=1000", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
    drive(BD, 1'b0, 1'b0);
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0100) begin errors++; $display("FAIL ch_dec_pulse got=%b exp=0100", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
  endtask

  task automatic test_priority();
    drive(BC, 1'b0, 1'b0);
    drive(BC | BU, 1'b0, 1'b0);
    checks++; if (bus.adj_mode !== 1'b1 || bus.field !== 2'd0 || bus.alarm_armed !== 1'b0) begin errors++; $display("FAIL prio_cu got=%b/%0d/%b exp=1/0/0", bus.adj_mode, bus.field, bus.alarm_armed); end
    drive(BL, 1'b0, 1'b0);
    drive(BL, 1'b0, 1'b0);
    drive(BU | BD, 1'b0, 1'b0);
    checks++; if (bus.alarm_hour !== 5'd0) begin errors++; $display("FAIL prio_ud got=%0d exp=0", bus.alarm_hour); end
    drive(BR | BU, 1'b0, 1'b0);
    checks++; if (bus.field !== 2'd3 || bus.alarm_hour !== 5'd0 || bus.alarm_min !== 6'd0) begin errors++; $display("FAIL prio_ru got=%0d %0d:%0d exp=3 0:0", bus.field, bus.alarm_hour, bus.alarm_min); end
    drive(BC, 1'b0, 1'b0);
    drive(BU, 1'b0, 1'b0);
    checks++; if (bus.alarm_armed !== 1'b1 || bus.adj_mode !== 1'b0) begin errors++; $display("FAIL arm_toggle got=%b/%b exp=1/0", bus.alarm_armed, bus.adj_mode); end
    drive(BD | BL | BR, 1'b0, 1'b0);
    checks++; if (bus.adj_mode !== 1'b0 || bus.field !== 2'd0 || bus.alarm_armed !== 1'b1) begin errors++; $display("FAIL clock_ignore got=%b/%0d/%b exp=0/0/1", bus.adj_mode, bus.field, bus.alarm_armed); end
  endtask

  task automatic test_reset_mid();
    drive(BC, 1'b0, 1'b0);
    drive(BL, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(BU, 1'b0, 1'b0);
    drive(BL, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(BU, 1'b0, 1'b0);
    checks++; if (bus.alarm_hour !== 5'd7 || bus.alarm_min !== 6'd30) begin errors++; $display("FAIL set_0730 got=%0d:%0d exp=7:30", bus.alarm_hour, bus.alarm_min); end
    drive(BR, 1'b0, 1'b0);
    drive(BR, 1'b0, 1'b0);
    drive(BR, 1'b0, 1'b0);
    drive(BU, 1'b0, 1'b1);
    checks++; if (bus.adj_mode !== 1'b0 || bus.field !== 2'd0 || bus.alarm_armed !== 1'b0) begin errors++; $display("FAIL rst_mid_state got=%b/%0d/%b exp=0/0/0", bus.adj_mode, bus.field, bus.alarm_armed); end
    checks++; if (bus.alarm_hour !== 5'd0 || bus.alarm_min !== 6'd0) begin errors++; $display("FAIL rst_mid_alarm got=%0d:%0d exp=0:0", bus.alarm_hour, bus.alarm_min); end
    checks++; if ({bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec} !== 4'b0000) begin errors++; $display("FAIL rst_mid_pulse got=%b exp=0000", {bus.ch_inc, bus.ch_dec, bus.cm_inc, bus.cm_dec}); end
  endtask

`ifdef AUTO_EXIT_EN
  task automatic test_timeout();
    drive(BC, 1'b0, 1'b0);
    drive(NB, 1'b1, 1'b0);
    drive(NB, 1'b1, 1'b0);
    checks++; if (bus.adj_mode !== 1'b1) begin errors++; $display("FAIL to_before got=%b exp=1", bus.adj_mode); end
    drive(NB, 1'b1, 1'b0);
    checks++; if (bus.adj_mode !== 1'b0) begin errors++; $display("FAIL to_exit got=%b exp=0", bus.adj_mode); end
    drive(BC, 1'b0, 1'b0);
    drive(NB, 1'b1, 1'b0);
    drive(NB, 1'b1, 1'b0);
    drive(BR, 1'b0, 1'b0);
    drive(NB, 1'b1, 1'b0);
    checks++; if (bus.adj_mode !== 1'b1 || bus.field !== 2'd1) begin errors++; $display("FAIL to_restart got=%b/%0d exp=1/1", bus.adj_mode, bus.field); end
    drive(NB, 1'b1, 1'b0);
    drive(BU, 1'b1, 1'b0);
    checks++; if (bus.adj_mode !== 1'b1 || bus.cm_inc !== 1'b1) begin errors++; $display("FAIL to_btn_wins got=%b/%b exp=1/1", bus.adj_mode, bus.cm_inc); end
  endtask
`else
  task automatic test_no_timeout();
    drive(BC, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(NB, 1'b1, 1'b0);
    checks++; if (bus.adj_mode !== 1'b1 || bus.field !== 2'd0) begin errors++; $display("FAIL no_timeout got=%b/%0d exp=1/0", bus.adj_mode, bus.field); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.btn_c = 0; bus.btn_r = 0; bus.btn_l = 0; bus.btn_u = 0; bus.btn_d = 0;
    bus.tick_1hz = 0;
    test_reset();
    test_navigation();
    test_alarm_wrap();
    test_pulses();
    test_priority();
    test_reset_mid();
`ifdef AUTO_EXIT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
